// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the handshaked pipeline stage register:
//   - default field widths for the ID/EX boundary (XLEN, RD_W, CTRL_W)
//   - bit positions of the individual controls inside the control bundle
//   - state encoding of the optional skid buffer (used when the build
//     defines PIPE_STAGE_SKID_EN)
//   - small helper functions shared by the stage and its skid buffer
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int RD_W   = 6;
    localparam int CTRL_W = 13;

    // Single-bit controls occupy bits 0..8, ALUOp sits above them.
    localparam int CTRL_REGWRT    = 0;
    localparam int CTRL_MEMTOREG  = 1;
    localparam int CTRL_PCTOREG   = 2;
    localparam int CTRL_MEMREAD   = 3;
    localparam int CTRL_MEMWRT    = 4;
    localparam int CTRL_BRNEG     = 5;
    localparam int CTRL_BRZERO    = 6;
    localparam int CTRL_JUMP      = 7;
    localparam int CTRL_JUMPMEM   = 8;
    localparam int CTRL_ALUOP_LSB = 9;
    localparam int CTRL_ALUOP_W   = 4;

    // Skid buffer occupancy: no beat, one beat at the output, and one beat
    // at the output plus one parked in the skid entry.
    localparam logic [1:0] SKID_EMPTY = 2'b00;
    localparam logic [1:0] SKID_FULL  = 2'b01;
    localparam logic [1:0] SKID_SKID  = 2'b10;

    // Width of one packed beat {ctrl, rs, rt, offset, rd}.
    function automatic int bundle_width(input int ctrl_w, input int xlen, input int rd_w);
        return ctrl_w + (3 * xlen) + rd_w;
    endfunction

    // True when the skid state machine has a beat in the output entry.
    function automatic logic skid_holds_beat(input logic [1:0] state);
        return (state != SKID_EMPTY);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Skid entry and occupancy state machine for pipe_stage_reg when built with
// PIPE_STAGE_SKID_EN. The output entry itself lives in the parent; this block
// tells the parent when to load it from the input, when to refill it from the
// skid entry, and when to clear its control bundle.
// in_ready is a pure register output, so a stall from the consumer reaches
// the producer one cycle late and the skid entry absorbs the beat in flight.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous kill of both entries
//   in_valid     producer presents a beat
//   out_ready    consumer takes the output beat
//   in_data      packed incoming beat (captured into the skid entry)
//   in_ready     registered: stage can accept this cycle
//   out_valid    output entry holds a beat
//   load_in      parent loads output entry from in_data
//   load_skid    parent loads output entry from skid_data
//   clear_out    parent clears the output control bundle (entry empties)
//   skid_data    contents of the skid entry
// -----------------------------------------------------------------------------
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic         out_ready,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic         load_in,
    output logic         load_skid,
    output logic         clear_out,
    output logic [W-1:0] skid_data
);

    logic [1:0]   state_r;
    logic [1:0]   state_nxt_s;
    logic         in_ready_r;
    logic [W-1:0] skid_r;
    logic         accept_s;
    logic         consume_s;
    logic         skid_load_s;

    assign accept_s  = in_valid & in_ready_r;
    assign consume_s = skid_holds_beat(state_r) & out_ready;

    // Next-state and entry-steering decode; flush overrides any transfer.
    always_comb begin
        state_nxt_s = state_r;
        load_in     = 1'b0;
        load_skid   = 1'b0;
        clear_out   = 1'b0;
        skid_load_s = 1'b0;
        if (flush) begin
            state_nxt_s = SKID_EMPTY;
            clear_out   = 1'b1;
        end else begin
            case (state_r)
                SKID_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = SKID_FULL;
                        load_in     = 1'b1;
                    end else begin
                        state_nxt_s = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (accept_s && consume_s) begin
                        state_nxt_s = SKID_FULL;
                        load_in     = 1'b1;
                    end else if (accept_s) begin
                        // Consumer stalled while in_ready was already high:
                        // park the in-flight beat.
                        state_nxt_s = SKID_SKID;
                        skid_load_s = 1'b1;
                    end else if (consume_s) begin
                        state_nxt_s = SKID_EMPTY;
                        clear_out   = 1'b1;
                    end else begin
                        state_nxt_s = SKID_FULL;
                    end
                end
                SKID_SKID: begin
                    // in_ready is low here, so only the skid beat can move.
                    if (consume_s) begin
                        state_nxt_s = SKID_FULL;
                        load_skid   = 1'b1;
                    end else begin
                        state_nxt_s = SKID_SKID;
                    end
                end
                default: begin
                    state_nxt_s = SKID_EMPTY;
                    clear_out   = 1'b1;
                end
            endcase
        end
    end

    // Occupancy state and registered in_ready, derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= SKID_EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s != SKID_SKID);
        end
    end

    // Skid entry captures the beat accepted while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_r <= {W{1'b0}};
        end else if (skid_load_s) begin
            skid_r <= in_data;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = skid_holds_beat(state_r);
    assign skid_data = skid_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Handshaked pipeline stage register carrying a control bundle plus
// rs/rt/offset/rd fields between two pipeline stages (ID/EX by default,
// reusable for EX/MEM and MEM/WB through the width parameters).
//
// Build option: define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with a
// registered in_ready. Without it the stage holds one entry and in_ready is
// combinational through out_ready.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush                            synchronous kill of all held beats
//   in_valid / in_ready              producer handshake
//   in_ctrl, in_rs, in_rt,
//   in_offset, in_rd                 incoming beat fields
//   out_valid / out_ready            consumer handshake
//   out_ctrl                         control bundle, zero whenever out_valid=0
//   out_rs, out_rt, out_offset,
//   out_rd                           held beat fields (not gated)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int RD_W   = pipe_pkg::RD_W,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   in_rs,
    input  logic [XLEN-1:0]   in_rt,
    input  logic [XLEN-1:0]   in_offset,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [XLEN-1:0]   out_rs,
    output logic [XLEN-1:0]   out_rt,
    output logic [XLEN-1:0]   out_offset,
    output logic [RD_W-1:0]   out_rd
);
    import pipe_pkg::*;

    localparam int W = bundle_width(CTRL_W, XLEN, RD_W);

    logic [W-1:0] in_bundle_s;
    logic [W-1:0] out_r;
    logic [W-1:0] skid_data_s;
    logic         valid_s;
    logic         load_in_s;
    logic         load_skid_s;
    logic         clear_out_s;

    assign in_bundle_s = {in_ctrl, in_rs, in_rt, in_offset, in_rd};

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_buf #(
        .W (W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_data   (in_bundle_s),
        .in_ready  (in_ready),
        .out_valid (valid_s),
        .load_in   (load_in_s),
        .load_skid (load_skid_s),
        .clear_out (clear_out_s),
        .skid_data (skid_data_s)
    );
`else
    logic valid_r;
    logic accept_s;
    logic consume_s;

    // Single entry: a free slot or a departing beat lets a new one in.
    assign in_ready    = !valid_r | out_ready;
    assign accept_s    = in_valid & in_ready;
    assign consume_s   = valid_r & out_ready;
    assign valid_s     = valid_r;
    assign skid_data_s = {W{1'b0}};
    assign load_skid_s = 1'b0;
    assign load_in_s   = accept_s & !flush;
    assign clear_out_s = flush | (consume_s & !accept_s);

    // Entry occupancy; flush wins over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
        end else if (consume_s) begin
            valid_r <= 1'b0;
        end
    end
`endif

    // Output entry. The control bundle is zeroed whenever the entry empties,
    // so out_ctrl comes straight from a register and a bubble can never
    // assert RegWrt/MemWrt/branch/jump. Data fields keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= {W{1'b0}};
        end else if (load_in_s) begin
            out_r <= in_bundle_s;
        end else if (load_skid_s) begin
            out_r <= skid_data_s;
        end else if (clear_out_s) begin
            out_r[W-1 -: CTRL_W] <= {CTRL_W{1'b0}};
        end
    end

    assign out_valid  = valid_s;
    assign out_ctrl   = out_r[W-1 -: CTRL_W];
    assign out_rs     = out_r[(3*XLEN)+RD_W-1 -: XLEN];
    assign out_rt     = out_r[(2*XLEN)+RD_W-1 -: XLEN];
    assign out_offset = out_r[XLEN+RD_W-1 -: XLEN];
    assign out_rd     = out_r[RD_W-1:0];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. A queue-based model of the stage
// (capacity 1, or 2 with PIPE_STAGE_SKID_EN) tracks every accepted beat;
// directed scenarios compare against constants and a randomized phase
// compares every output against the model each cycle.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int XLEN   = 32;
    localparam int RD_W   = 6;
    localparam int CTRL_W = 13;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [XLEN-1:0]   in_rs;
    logic [XLEN-1:0]   in_rt;
    logic [XLEN-1:0]   in_offset;
    logic [RD_W-1:0]   in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [XLEN-1:0]   out_rs;
    logic [XLEN-1:0]   out_rt;
    logic [XLEN-1:0]   out_offset;
    logic [RD_W-1:0]   out_rd;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   rs;
        logic [XLEN-1:0]   rt;
        logic [XLEN-1:0]   off;
        logic [RD_W-1:0]   rd;
    } beat_t;

    beat_t mq[$];
    beat_t last_out;
    int    n_tests;
    int    n_fail;

    pipe_stage_reg #(
        .XLEN   (XLEN),
        .RD_W   (RD_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_offset  (in_offset),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_offset (out_offset),
        .out_rd     (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: base stage takes a beat when empty or when the held beat leaves;
    // skid stage takes a beat whenever fewer than two are held.
    function automatic logic exp_ready();
        if (DEPTH == 1) return (mq.size() == 0) || out_ready;
        else            return (mq.size() < 2);
    endfunction

    task automatic model_reset();
        mq.delete();
        last_out = '0;
    endtask

    task automatic rand_beat();
        in_ctrl   = CTRL_W'($urandom);
        in_rs     = $urandom;
        in_rt     = $urandom;
        in_offset = $urandom;
        in_rd     = RD_W'($urandom);
    endtask

    // One clock edge: update the model from the inputs seen at the edge.
    task automatic tick();
        logic  rdy;
        logic  acc;
        logic  con;
        beat_t b;
        @(posedge clk);
        rdy = exp_ready();
        acc = in_valid && rdy;
        con = (mq.size() != 0) && out_ready;
        b   = {in_ctrl, in_rs, in_rt, in_offset, in_rd};
        if (flush) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back(b);
        end
        if (mq.size() != 0) last_out = mq[0];
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 13'h1FFF;
        in_rs     = 32'h1111_1111;
        in_rt     = 32'h2222_2222;
        in_offset = 32'h3333_3333;
        in_rd     = 6'd63;
        out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_ctrl !== 13'h0) begin n_fail++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
        n_tests++; if (out_rd !== 6'd0) begin n_fail++; $display("FAIL reset_out_rd: got %0d want 0", out_rd); end
        n_tests++; if (out_rs !== 32'h0) begin n_fail++; $display("FAIL reset_out_rs: got %h want 0", out_rs); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        in_ctrl = 13'h0A5;
        in_rs   = 32'hDEADBEEF;
        in_rd   = 6'd5;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_out_valid: got %b want 1", out_valid); end
        n_tests++; if (out_rs !== 32'hDEADBEEF) begin n_fail++; $display("FAIL first_out_rs: got %h want deadbeef", out_rs); end
        n_tests++; if (out_rd !== 6'd5) begin n_fail++; $display("FAIL first_out_rd: got %0d want 5", out_rd); end
        n_tests++; if (out_ctrl !== 13'h0A5) begin n_fail++; $display("FAIL first_out_ctrl: got %h want 0a5", out_ctrl); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        idle(2);
        for (int i = 1; i <= 8; i++) begin
            rand_beat();
            in_valid = 1'b1;
            in_rs    = 32'(i);
            #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready beat %0d: got %b want 1", i, in_ready); end
            if (i > 1) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_rs !== 32'(i - 1)) begin
                    n_fail++; $display("FAIL b2b_out beat %0d: got v=%b rs=%0d want v=1 rs=%0d", i - 1, out_valid, out_rs, i - 1);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_rs !== 32'd8) begin n_fail++; $display("FAIL b2b_last: got v=%b rs=%0d want v=1 rs=8", out_valid, out_rs); end
        tick();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
        idle(1);
    endtask

    task automatic test_stall();
        idle(1);
        rand_beat();
        in_ctrl   = 13'h1F3;
        in_rt     = 32'h12345678;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        rand_beat();
        in_rt = 32'h9ABCDEF0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (out_valid !== 1'b1 || out_rt !== 32'h12345678 || out_ctrl !== 13'h1F3) begin
                n_fail++; $display("FAIL stall_hold cycle %0d: got v=%b rt=%h ctrl=%h want v=1 rt=12345678 ctrl=1f3", k, out_valid, out_rt, out_ctrl);
            end
            n_tests++; if (in_ready !== ((DEPTH == 2) && (k == 0))) begin
                n_fail++; $display("FAIL stall_in_ready cycle %0d: got %b want %b", k, in_ready, ((DEPTH == 2) && (k == 0)));
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_tests++; if (out_rt !== 32'h12345678) begin n_fail++; $display("FAIL stall_first_exit: got %h want 12345678", out_rt); end
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_rt !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL stall_second_exit: got v=%b rt=%h want v=1 rt=9abcdef0", out_valid, out_rt); end
        tick();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained: got %b want 0", out_valid); end
        idle(1);
    endtask

    task automatic test_flush();
        idle(1);
        rand_beat();
        in_ctrl   = 13'h0FF;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        rand_beat();
        in_ctrl = 13'h1AA;
        flush   = 1'b1;
        #1;
        n_tests++; if (in_ready !== (DEPTH == 2)) begin n_fail++; $display("FAIL flush_in_ready: got %b want %b", in_ready, (DEPTH == 2)); end
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (out_valid !== 1'b0 || out_ctrl !== 13'h0) begin
                n_fail++; $display("FAIL flush_empty cycle %0d: got v=%b ctrl=%h want v=0 ctrl=0", k, out_valid, out_ctrl);
            end
            tick();
        end
    endtask

    task automatic test_bubble_gating();
        idle(1);
        rand_beat();
        in_ctrl  = 13'h091;
        in_rs    = 32'hCAFEF00D;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_ctrl !== 13'h091) begin n_fail++; $display("FAIL bubble_pre: got v=%b ctrl=%h want v=1 ctrl=091", out_valid, out_ctrl); end
        tick();
        #1;
        n_tests++; if (out_valid !== 1'b0 || out_ctrl !== 13'h0) begin n_fail++; $display("FAIL bubble_gate: got v=%b ctrl=%h want v=0 ctrl=0", out_valid, out_ctrl); end
        n_tests++; if (out_rs !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bubble_rs_kept: got %h want cafef00d", out_rs); end
    endtask

    task automatic test_async_reset();
        idle(1);
        rand_beat();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        rand_beat();
        tick();
        #1;
        n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid); end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (out_valid !== 1'b0 || out_ctrl !== 13'h0) begin n_fail++; $display("FAIL areset_now: got v=%b ctrl=%h want v=0 ctrl=0", out_valid, out_ctrl); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (out_rs !== 32'h0) begin n_fail++; $display("FAIL areset_rs: got %h want 0", out_rs); end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        out_ready = 1'b1;
        tick();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_no_survivor: got %b want 0", out_valid); end
        idle(1);
    endtask

    task automatic test_random();
        logic  ev;
        beat_t f;
        for (int c = 0; c < 400; c++) begin
            rand_beat();
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            flush     = ($urandom_range(15, 0) == 0);
            #1;
            ev = (mq.size() != 0);
            f  = ev ? mq[0] : last_out;
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, out_valid, ev); end
            n_tests++; if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_in_ready c%0d: got %b want %b", c, in_ready, exp_ready()); end
            n_tests++; if (out_ctrl !== (ev ? f.ctrl : 13'h0)) begin n_fail++; $display("FAIL rand_ctrl c%0d: got %h want %h", c, out_ctrl, (ev ? f.ctrl : 13'h0)); end
            n_tests++; if (out_rs !== f.rs || out_rt !== f.rt || out_offset !== f.off || out_rd !== f.rd) begin
                n_fail++; $display("FAIL rand_data c%0d: got %h/%h/%h/%h want %h/%h/%h/%h", c, out_rs, out_rt, out_offset, out_rd, f.rs, f.rt, f.off, f.rd);
            end
            tick();
        end
        idle(3);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_bubble_gating();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
